// File: rtl/ppu_sched.sv
// Round-robin scheduler that shares one ppu between NREQ requesters and drains the ppu before each mode change.
// Optional build macro PPU_SCHED_STATS_EN adds saturating issue/drain/switch statistics outputs.
//
// state  | meaning
// IDLE   | no requests seen; mode held
// RUN0   | mode0, one beat per grant, round-robin
// RUN1A  | mode1, first beat of a locked pair (tag vld=0)
// RUN1B  | mode1, second beat of the pair (tag vld=1)
// DRAIN  | no grants; waits for ppu pipeline empty, then flips mode
module ppu_sched #(
    parameter int  NREQ     = 4,
    parameter int  PPU_LAT  = 8,
    parameter int  MAX_WAIT = 64,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [NREQ-1:0] req_mode_i,
    output logic [NREQ-1:0] req_ready_o,
    output logic [IDW-1:0]  grant_idx_o,
    output logic            ppu_mode_o,
    output logic [IDW:0]    ppu_in_tag_o,
    input  logic [IDW:0]    ppu_out_tag_i,
    output logic [NREQ-1:0] rsp_valid_o,
`ifdef PPU_SCHED_STATS_EN
    output logic [31:0]     stat_issue_o,
    output logic [31:0]     stat_drain_o,
    output logic [15:0]     stat_switch_o,
`endif
    output logic            busy_o
);

    localparam int DCW = $clog2(PPU_LAT + 1);
    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [DCW-1:0] LAT_V  = DCW'(PPU_LAT);
    localparam logic [WCW-1:0] WAIT_V = WCW'(MAX_WAIT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN0  = 3'd1;
    localparam logic [2:0] S_RUN1A = 3'd2;
    localparam logic [2:0] S_RUN1B = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]     state_q, state_d;
    logic           mode_q, mode_d;
    logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
    logic [DCW-1:0] mask_cnt_q, mask_cnt_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;

    logic [NREQ-1:0] same_v, other_v;
    logic            win_found;
    logic [IDW-1:0]  win_idx;
    logic            issue, tag_vld, flip_now;
    logic [IDW-1:0]  gnt_idx;

    assign same_v   = req_valid_i & ~(req_mode_i ^ {NREQ{mode_q}});
    assign other_v  = req_valid_i &  (req_mode_i ^ {NREQ{mode_q}});
    assign flip_now = (state_q == S_DRAIN) && (drain_cnt_q == '0);

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && same_v[IDW'((int'(rr_ptr_q) + k) % NREQ)]) begin
                win_found = 1'b1;
                win_idx   = IDW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        issue     = 1'b0;
        tag_vld   = 1'b0;
        gnt_idx   = '0;
        case (state_q)
            S_IDLE: begin
                if (|req_valid_i)
                    state_d = (|same_v) ? (mode_q ? S_RUN1A : S_RUN0) : S_DRAIN;
            end
            S_RUN0, S_RUN1A: begin
                // Dropping to zero requests takes priority over a pending switch.
                if (!(|req_valid_i)) begin
                    state_d = S_IDLE;
                end else if (!(|same_v) || (wait_cnt_q >= WAIT_V)) begin
                    state_d = S_DRAIN;
                end else begin
                    issue    = 1'b1;
                    gnt_idx  = win_idx;
                    rr_ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
                    if (state_q == S_RUN0) begin
                        tag_vld = 1'b1;
                    end else begin
                        lock_id_d = win_idx;
                        state_d   = S_RUN1B;
                    end
                end
            end
            S_RUN1B: begin
                issue   = 1'b1;
                tag_vld = 1'b1;
                gnt_idx = lock_id_q;
                state_d = S_RUN1A;
            end
            S_DRAIN: begin
                if (flip_now) begin
                    mode_d  = ~mode_q;
                    state_d = mode_q ? S_RUN0 : S_RUN1A;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_DRAIN) || (state_d == S_DRAIN))
            wait_cnt_d = '0;
        else if ((|other_v) && (wait_cnt_q < WAIT_V))
            wait_cnt_d = wait_cnt_q + WCW'(1);
        else
            wait_cnt_d = wait_cnt_q;
    end

    assign drain_cnt_d = issue ? LAT_V :
                         ((drain_cnt_q != '0) ? drain_cnt_q - DCW'(1) : '0);
    assign mask_cnt_d  = (mask_cnt_q != '0) ? mask_cnt_q - DCW'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            drain_cnt_q <= '0;
            mask_cnt_q  <= LAT_V;
            wait_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            lock_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            drain_cnt_q <= drain_cnt_d;
            mask_cnt_q  <= mask_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_id_q   <= lock_id_d;
        end
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready_o[i] = issue && (gnt_idx == IDW'(i));
            rsp_valid_o[i] = ppu_out_tag_i[IDW] && (ppu_out_tag_i[IDW-1:0] == IDW'(i)) &&
                             (mask_cnt_q == '0);
        end
    end

    assign grant_idx_o  = gnt_idx;
    assign ppu_in_tag_o = issue ? {tag_vld, gnt_idx} : '0;
    // The pipeline is already empty in the final drain cycle, so the new mode shows one cycle early.
    assign ppu_mode_o   = mode_q ^ flip_now;
    assign busy_o       = (state_q != S_IDLE) || (drain_cnt_q != '0);

`ifdef PPU_SCHED_STATS_EN
    logic [31:0] stat_issue_q;
    logic [31:0] stat_drain_q;
    logic [15:0] stat_switch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issue_q  <= '0;
            stat_drain_q  <= '0;
            stat_switch_q <= '0;
        end else begin
            if (issue && (stat_issue_q != '1))
                stat_issue_q <= stat_issue_q + 32'd1;
            if ((state_q == S_DRAIN) && (stat_drain_q != '1))
                stat_drain_q <= stat_drain_q + 32'd1;
            if (flip_now && (stat_switch_q != '1))
                stat_switch_q <= stat_switch_q + 16'd1;
        end
    end

    assign stat_issue_o  = stat_issue_q;
    assign stat_drain_o  = stat_drain_q;
    assign stat_switch_o = stat_switch_q;
`endif

endmodule

// File: tb/tb_ppu_sched.sv
// Bench for ppu_sched: reset-free ppu tag delay line, per-cycle scheduling model, directed scenarios.
module tb_ppu_sched;

    localparam int NREQ = 4;
    localparam int PPU_LAT = 8;
    localparam int MAX_WAIT = 64;
    localparam int LOGN = 2048;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [3:0] req_mode;
    logic [3:0] req_ready;
    logic [1:0] grant_idx;
    logic       ppu_mode;
    logic [2:0] ppu_in_tag;
    logic [2:0] ppu_out_tag;
    logic [3:0] rsp_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [3:0] log_ready [0:LOGN-1];
    logic [2:0] log_tag   [0:LOGN-1];
    logic       log_pmode [0:LOGN-1];
    logic [3:0] log_rsp   [0:LOGN-1];
    logic       log_busy  [0:LOGN-1];

    ppu_sched #(.NREQ(NREQ), .PPU_LAT(PPU_LAT), .MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_mode_i   (req_mode),
        .req_ready_o  (req_ready),
        .grant_idx_o  (grant_idx),
        .ppu_mode_o   (ppu_mode),
        .ppu_in_tag_o (ppu_in_tag),
        .ppu_out_tag_i(ppu_out_tag),
        .rsp_valid_o  (rsp_valid),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // ppu tag path: no reset, powers up full of stale valid tags
    logic [2:0] pipe [0:PPU_LAT-1];
    logic       primed = 1'b0;
    always @(posedge clk) begin
        if (!primed) begin
            for (int i = 0; i < PPU_LAT; i++) pipe[i] <= {1'b1, 2'(i)};
            primed <= 1'b1;
        end else begin
            for (int i = PPU_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= ppu_in_tag;
        end
    end
    assign ppu_out_tag = pipe[PPU_LAT-1];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Scheduling model: phase + timestamp of the last issue
    localparam int P_IDLE = 0, P_SERVE = 1, P_PAIR2 = 2, P_DRAIN = 3;
    int m_mode, m_phase, m_rr, m_wait, m_last, m_pair, m_since;

    initial begin
        int e_ready, e_gidx, e_tag, e_pmode, e_rsp, e_busy, nxt, w, idx;
        bit same, other, was_drain, flip;
        m_mode = 0; m_phase = P_IDLE; m_rr = 0; m_wait = 0; m_last = -1000; m_pair = 0; m_since = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_ready", req_ready, 0);
                chk("rst_tag", ppu_in_tag, 0);
                chk("rst_gidx", grant_idx, 0);
                chk("rst_pmode", ppu_mode, 0);
                chk("rst_rsp", rsp_valid, 0);
                chk("rst_busy", busy, 0);
                m_mode = 0; m_phase = P_IDLE; m_rr = 0; m_wait = 0; m_last = -1000; m_since = 0;
            end else begin
                e_ready = 0; e_gidx = 0; e_tag = 0; e_pmode = m_mode; flip = 0;
                e_busy = (m_phase != P_IDLE) || (cyc - m_last <= PPU_LAT);
                same = 0; other = 0;
                for (int i = 0; i < NREQ; i++)
                    if (req_valid[i]) begin
                        if (int'(req_mode[i]) == m_mode) same = 1; else other = 1;
                    end
                was_drain = (m_phase == P_DRAIN);
                nxt = m_phase;
                case (m_phase)
                    P_IDLE: if (req_valid != 0) nxt = same ? P_SERVE : P_DRAIN;
                    P_SERVE: begin
                        if (req_valid == 0) nxt = P_IDLE;
                        else if (!same || m_wait >= MAX_WAIT) nxt = P_DRAIN;
                        else begin
                            w = -1;
                            for (int k = 0; k < NREQ; k++) begin
                                idx = (m_rr + k) % NREQ;
                                if (w < 0 && req_valid[idx] && int'(req_mode[idx]) == m_mode) w = idx;
                            end
                            e_ready = 1 << w; e_gidx = w; m_rr = (w + 1) % NREQ; m_last = cyc;
                            if (m_mode == 0) e_tag = 4 + w;
                            else begin e_tag = w; m_pair = w; nxt = P_PAIR2; end
                        end
                    end
                    P_PAIR2: begin
                        e_ready = 1 << m_pair; e_gidx = m_pair; e_tag = 4 + m_pair;
                        m_last = cyc; nxt = P_SERVE;
                    end
                    default: begin
                        if (cyc >= m_last + PPU_LAT + 1) begin
                            flip = 1; e_pmode = 1 - m_mode; nxt = P_SERVE;
                        end
                    end
                endcase
                if (was_drain || nxt == P_DRAIN) m_wait = 0;
                else if (other && m_wait < MAX_WAIT) m_wait++;
                if (flip) m_mode = 1 - m_mode;
                m_phase = nxt;
                e_rsp = (m_since >= PPU_LAT && ppu_out_tag[2]) ? (1 << ppu_out_tag[1:0]) : 0;
                chk("ready", req_ready, e_ready);
                if (e_ready != 0) chk("gidx", grant_idx, e_gidx);
                chk("in_tag", ppu_in_tag, e_tag);
                chk("pmode", ppu_mode, e_pmode);
                chk("rsp", rsp_valid, e_rsp);
                chk("busy", busy, e_busy);
                m_since++;
            end
            if (cyc < LOGN) begin
                log_ready[cyc] = req_ready; log_tag[cyc] = ppu_in_tag; log_pmode[cyc] = ppu_mode;
                log_rsp[cyc] = rsp_valid; log_busy[cyc] = busy;
            end
            cyc++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int rsp_cnt(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (log_rsp[c] != 0) n++;
        return n;
    endfunction

    initial begin
        int t, l, s, u;
        int rr_seq [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
        rst_n = 1'b0; req_valid = '0; req_mode = '0;
        step(3);
        rst_n = 1'b1;
        step(10);

        // 1: req0 mode0, five beats, responses 8 cycles later
        t = cyc; req_valid = 4'b0001; req_mode = 4'b0000;
        step(6); req_valid = '0; step(14);
        chk("t1_idle_first", log_ready[t], 0);
        for (int k = 1; k <= 5; k++) chk("t1_ready", log_ready[t+k], 1);
        chk("t1_stop", log_ready[t+6], 0);
        chk("t1_rsp_early", log_rsp[t+8], 0);
        chk("t1_rsp_first", log_rsp[t+9], 1);
        chk("t1_rsp_count", rsp_cnt(t, t+19), 5);

        // 2: req1 mode1 pair after drain
        t = cyc; req_valid = 4'b0010; req_mode = 4'b0010;
        step(4); req_valid = '0; req_mode = '0; step(16);
        chk("t2_mode", log_pmode[t+1], 1);
        chk("t2_tag_a", log_tag[t+2], 3'b001);
        chk("t2_tag_b", log_tag[t+3], 3'b101);
        chk("t2_ready_b", log_ready[t+3], 4'b0010);
        chk("t2_rsp_at", log_rsp[t+11], 4'b0010);
        chk("t2_rsp_count", rsp_cnt(t, t+19), 1);

        // 3: drain timing from last mode0 issue to first mode1 grant
        t = cyc; req_valid = 4'b0001; req_mode = 4'b0000;
        step(5); l = t + 4;
        req_valid = 4'b0100; req_mode = 4'b0100;
        step(11); req_valid = '0; req_mode = '0; step(14);
        chk("t3_last", log_ready[l], 4'b0001);
        chk("t3_nogrant", log_ready[l+1], 0);
        chk("t3_mode_old", log_pmode[l+8], 0);
        chk("t3_mode_new", log_pmode[l+9], 1);
        chk("t3_busy_drain", log_busy[l+5], 1);
        chk("t3_no_early", log_ready[l+9], 0);
        chk("t3_first", log_ready[l+10], 4'b0100);
        chk("t3_tag_a", log_tag[l+10], 3'b010);
        chk("t3_tag_b", log_tag[l+11], 3'b110);

        // 4: all four mode0, round-robin continuing from pointer 3
        t = cyc; req_valid = 4'b1111; req_mode = 4'b0000;
        step(10); req_valid = '0; step(4);
        for (int k = 0; k < 8; k++) chk("t4_rr", log_ready[t+2+k], 1 << rr_seq[k]);

        // 5: req3 mode1 starved until the wait limit forces a switch
        s = cyc; req_valid = 4'b1001; req_mode = 4'b1000;
        step(75); req_valid = 4'b0001; req_mode = 4'b0000;
        step(11); req_valid = '0; step(6);
        chk("t5_first", log_ready[s+1], 4'b0001);
        chk("t5_last", log_ready[s+63], 4'b0001);
        chk("t5_forced", log_ready[s+64], 0);
        chk("t5_mode_old", log_pmode[s+71], 0);
        chk("t5_mode_new", log_pmode[s+72], 1);
        chk("t5_tag_a", log_tag[s+73], 3'b011);
        chk("t5_tag_b", log_tag[s+74], 3'b111);
        chk("t5_rsp", log_rsp[s+82], 4'b1000);

        // 6: one-cycle reset with tags in flight
        u = cyc; req_valid = 4'b1111; req_mode = 4'b0000;
        step(5); rst_n = 1'b0;
        step(1); rst_n = 1'b1;
        step(12); req_valid = '0; step(12);
        chk("t6_pre", log_ready[u+4], 4'b0001);
        chk("t6_rst_ready", log_ready[u+5], 0);
        chk("t6_rst_busy", log_busy[u+5], 0);
        chk("t6_idle", log_ready[u+6], 0);
        chk("t6_regrant", log_ready[u+7], 4'b0001);
        chk("t6_masked", rsp_cnt(u+5, u+14), 0);
        chk("t6_rsp_back", log_rsp[u+15], 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
